// File: rtl/alu_hs_seq_g13_pkg.sv
// alu_hs_seq_g13_pkg: op_code encodings and FSM state type
// shared by the handshaked ALU and its multiplier.
package alu_hs_seq_g13_pkg;

    localparam logic [3:0] OP_ADD     = 4'h0;
    localparam logic [3:0] OP_SUB     = 4'h1;
    localparam logic [3:0] OP_AND     = 4'h2;
    localparam logic [3:0] OP_OR      = 4'h3;
    localparam logic [3:0] OP_XNOR    = 4'h4;
    localparam logic [3:0] OP_GT      = 4'h5;
    localparam logic [3:0] OP_SLL     = 4'h6;
    localparam logic [3:0] OP_SRL     = 4'h7;
    localparam logic [3:0] OP_SUBEQ   = 4'h8;
    localparam logic [3:0] OP_SRLGT   = 4'h9;
    localparam logic [3:0] OP_SLLGT   = 4'hA;
    localparam logic [3:0] OP_MUL     = 4'hB;
    localparam logic [3:0] OP_ILL_MIN = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_hs_seq_g13_mul_iter.sv
// alu_hs_seq_g13_mul_iter: radix-2 shift-add unsigned multiplier.
// The first partial step runs in the start cycle, so done follows WIDTH-1 cycles later.
module alu_hs_seq_g13_mul_iter #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_prod
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_a;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;

    logic [2*WIDTH-1:0] w_src;
    logic [WIDTH-1:0]   w_mcand;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_next;

    // One shift-add step: add multiplicand to the high half when the
    // current multiplier LSB is set, then shift the whole product right.
    always_comb begin
        w_src   = i_start ? {{WIDTH{1'b0}}, i_b} : r_prod;
        w_mcand = i_start ? i_a : r_a;
        w_sum   = {1'b0, w_src[2*WIDTH-1:WIDTH]}
                + (w_src[0] ? {1'b0, w_mcand} : {(WIDTH+1){1'b0}});
        w_next  = {w_sum, w_src[WIDTH-1:1]};
    end

    // Load on start, iterate while busy, hold the product once complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod <= '0;
            r_a    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_a    <= i_a;
            r_prod <= w_next;
            r_cnt  <= CW'(1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == CW'(WIDTH)) begin
                r_busy <= 1'b0;
            end else begin
                r_prod <= w_next;
                r_cnt  <= r_cnt + CW'(1);
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == CW'(WIDTH));
    assign o_prod = r_prod;

endmodule

// File: rtl/alu_hs_seq_g13.sv
// alu_hs_seq_g13: valid/ready ALU with single-cycle ops and an iterative multiply.
// Owns the control FSM, the single-cycle datapath and the result register.
module alu_hs_seq_g13
    import alu_hs_seq_g13_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shift_amt,
    input  logic [SHW-1:0]   sub_start,
    input  logic [SHW-1:0]   sub_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] O,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             illegal
);

    localparam int MSB = WIDTH - 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_o;
    logic             r_carry;
    logic             r_ovf;
    logic             r_zero;
    logic             r_ill;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_start_mul;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_ill;

    assign w_add  = {1'b0, A} + {1'b0, B};
    assign w_sub  = {1'b0, A} - {1'b0, B};
    assign w_shl  = A << shift_amt;
    assign w_mask = (WIDTH'(1) << sub_len) - WIDTH'(1);

    assign w_in_ready  = (r_state == ST_IDLE)
                      || ((r_state == ST_DONE) && out_ready);
    assign w_accept    = in_valid && w_in_ready;
    assign w_start_mul = w_accept && (op_code == OP_MUL);

    // Single-cycle result and flags for the op presented at the input.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_ill = 1'b0;
        case (op_code)
            OP_ADD: begin
                w_res = w_add[MSB:0];
                w_c   = w_add[WIDTH];
                w_v   = (A[MSB] == B[MSB]) && (w_add[MSB] != A[MSB]);
            end
            OP_SUB: begin
                w_res = w_sub[MSB:0];
                w_c   = w_sub[WIDTH];
                w_v   = (A[MSB] != B[MSB]) && (w_sub[MSB] != A[MSB]);
            end
            OP_AND:   w_res = A & B;
            OP_OR:    w_res = A | B;
            OP_XNOR:  w_res = ~(A ^ B);
            OP_GT:    w_res[0] = A > B;
            OP_SLL:   w_res = w_shl;
            OP_SRL:   w_res = A >> shift_amt;
            OP_SUBEQ: w_res[0] = ((A >> sub_start) & w_mask)
                              == ((B >> sub_start) & w_mask);
            OP_SRLGT: w_res[0] = (A >> shift_amt) > B;
            OP_SLLGT: w_res[0] = w_shl > B;
            OP_MUL:   w_res = '0;
            default:  w_ill = (op_code >= OP_ILL_MIN);
        endcase
    end

    alu_hs_seq_g13_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start_mul),
        .i_a     (A),
        .i_b     (B),
        .o_busy  (w_mul_busy),
        .o_done  (w_mul_done),
        .o_prod  (w_prod)
    );

    // Control FSM and result register: accept, wait for multiply, hold until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_o     <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_ill   <= 1'b0;
        end else if (w_accept) begin
            if (op_code == OP_MUL) begin
                r_state <= ST_MUL;
            end else begin
                r_state <= ST_DONE;
                r_o     <= w_res;
                r_carry <= w_c;
                r_ovf   <= w_v;
                r_zero  <= (w_res == '0);
                r_ill   <= w_ill;
            end
        end else begin
            unique case (r_state)
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_state <= ST_DONE;
                        r_o     <= w_prod[MSB:0];
                        r_carry <= |w_prod[2*WIDTH-1:WIDTH];
                        r_ovf   <= 1'b0;
                        r_zero  <= (w_prod[MSB:0] == '0);
                        r_ill   <= 1'b0;
                    end else if (!w_mul_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == ST_DONE);
    assign O         = r_o;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign illegal   = r_ill;

endmodule
